// File: rtl/qdiv_dispatch_if.sv
// qdiv_dispatch_if: request stream, result stream and divider-side signals
// of the qdiv_dispatch front end, bundled for a single interface port.
// slave  = dispatcher view, master = surrounding system view.
interface qdiv_dispatch_if #(
    parameter int unsigned N = 32
) ();
    // Request stream
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;

    // Result stream
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_quotient;
    logic         o_overflow;
    logic         o_div_zero;

    // Divider side
    logic [N-1:0] o_div_dividend;
    logic [N-1:0] o_div_divisor;
    logic         o_div_start;
    logic [N-1:0] i_div_quotient;
    logic         i_div_complete;
    logic         i_div_overflow;

    modport slave (
        input  i_valid, i_dividend, i_divisor,
        output o_ready,
        output o_valid, o_quotient, o_overflow, o_div_zero,
        input  i_ready,
        output o_div_dividend, o_div_divisor, o_div_start,
        input  i_div_quotient, i_div_complete, i_div_overflow
    );

    modport master (
        output i_valid, i_dividend, i_divisor,
        input  o_ready,
        input  o_valid, o_quotient, o_overflow, o_div_zero,
        output i_ready,
        input  o_div_dividend, o_div_divisor, o_div_start,
        output i_div_quotient, i_div_complete, i_div_overflow
    );
endinterface

// File: rtl/qdiv_dispatch.sv
// qdiv_dispatch: request FIFO and issue sequencer in front of the multi-cycle
// Q-format divider. One start pulse per request, one registered result slot.
// Optional divide-by-zero trap: define QDIV_DISPATCH_DIVZERO_EN.
module qdiv_dispatch #(
    parameter int unsigned Q     = 15,
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           rst_n,
    qdiv_dispatch_if.slave bus
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || Q >= N - 1) begin : g_cfg_err
        $error("qdiv_dispatch: DEPTH must be a power of two >= 2 and Q < N-1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        BUSY  = 2'd3
    } state_e;

    typedef struct packed {
        logic [N-1:0] dividend;
        logic [N-1:0] divisor;
    } req_t;

    req_t         mem_q [DEPTH];
    req_t         mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    state_e       state_q, state_d;
    logic         valid_q, valid_d;
    logic [N-1:0] quot_q, quot_d;
    logic         ovf_q, ovf_d;
    logic [N-1:0] div_dividend_q, div_dividend_d;
    logic [N-1:0] div_divisor_q, div_divisor_d;
    logic         start_q, start_d;
`ifdef QDIV_DISPATCH_DIVZERO_EN
    logic         dz_q, dz_d;
    logic         trap;
`endif

    logic         empty;
    logic         full;
    logic         slot_free;
    logic         push;
    logic         pop;
    req_t         head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign slot_free = !valid_q || bus.i_ready;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

`ifdef QDIV_DISPATCH_DIVZERO_EN
    assign trap = (head.divisor[N-2:0] == '0);
`endif

    // Next-state logic: FIFO push/pop, issue sequencing and result slot.
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        state_d        = state_q;
        valid_d        = valid_q;
        quot_d         = quot_q;
        ovf_d          = ovf_q;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        start_d        = 1'b0;
`ifdef QDIV_DISPATCH_DIVZERO_EN
        dz_d           = dz_q;
`endif
        pop            = 1'b0;
        push           = bus.i_valid && !full;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {bus.i_dividend, bus.i_divisor};
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end

        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!empty && slot_free) begin
`ifdef QDIV_DISPATCH_DIVZERO_EN
                    if (trap) begin
                        // Zero divisor answered locally; divider state is irrelevant.
                        pop     = 1'b1;
                        quot_d  = {head.dividend[N-1] ^ head.divisor[N-1], {(N-1){1'b1}}};
                        ovf_d   = 1'b1;
                        dz_d    = 1'b1;
                        valid_d = 1'b1;
                    end else
`endif
                    if (bus.i_div_complete) begin
                        pop            = 1'b1;
                        div_dividend_d = head.dividend;
                        div_divisor_d  = head.divisor;
                        start_d        = 1'b1;
                        state_d        = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = ACK;
            end
            ACK: begin
                if (!bus.i_div_complete) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.i_div_complete) begin
                    quot_d  = bus.i_div_quotient;
                    ovf_d   = bus.i_div_overflow;
`ifdef QDIV_DISPATCH_DIVZERO_EN
                    dz_d    = 1'b0;
`endif
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Control, pointer and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            state_q        <= IDLE;
            valid_q        <= 1'b0;
            quot_q         <= '0;
            ovf_q          <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            start_q        <= 1'b0;
`ifdef QDIV_DISPATCH_DIVZERO_EN
            dz_q           <= 1'b0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            state_q        <= state_d;
            valid_q        <= valid_d;
            quot_q         <= quot_d;
            ovf_q          <= ovf_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            start_q        <= start_d;
`ifdef QDIV_DISPATCH_DIVZERO_EN
            dz_q           <= dz_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign bus.o_ready        = !full;
    assign bus.o_valid        = valid_q;
    assign bus.o_quotient     = quot_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_div_dividend = div_dividend_q;
    assign bus.o_div_divisor  = div_divisor_q;
    assign bus.o_div_start    = start_q;
`ifdef QDIV_DISPATCH_DIVZERO_EN
    assign bus.o_div_zero     = dz_q;
`else
    assign bus.o_div_zero     = 1'b0;
`endif

endmodule
